// File: rtl/regfile_pkg.sv
// Shared register-file definitions used by the operand-fetch stage and the write-back unit.
// Holds widths, the write-back bundle layout and its packed struct view.
package regfile_pkg;

    localparam int unsigned DATA_W      = 64;
    localparam int unsigned ADDR_W      = 4;
    localparam int unsigned NUM_REGS    = 16;

    // Write-back bundle: {is_write, address, value}
    localparam int unsigned WB_BUNDLE_W = 69;
    localparam int unsigned WB_WE_BIT   = 68;
    localparam int unsigned WB_ADDR_HI  = 67;
    localparam int unsigned WB_ADDR_LO  = 64;
    localparam int unsigned WB_DATA_HI  = 63;
    localparam int unsigned WB_DATA_LO  = 0;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_bundle_t;

endpackage : regfile_pkg

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   set_en/set_addr          mark a register as having a pending write
//   clr_en/clr_addr          write-back completed for a register
//   rd_addr_a/b, rd_addr_dst lookup addresses
//   busy_a_c/b_c/dst_c       combinational busy lookups (pre-update state)
module reg_scoreboard
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    input  logic [ADDR_W-1:0] rd_addr_dst,
    output logic              busy_a_c,
    output logic              busy_b_c,
    output logic              busy_dst_c
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Lookups see the current state, so a source equal to its own destination
    // is checked before the new pending write is recorded.
    assign busy_a_c   = busy_q[rd_addr_a];
    assign busy_b_c   = busy_q[rd_addr_b];
    assign busy_dst_c = busy_q[rd_addr_dst];

    // Clear first, then set: a newly issued write outranks a completing older one.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_addr] = 1'b0;
        end
        if (set_en) begin
            busy_d[set_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule : reg_scoreboard

// File: rtl/register_read.sv
// Operand-fetch stage: reads the register file, bypasses same-cycle write-back,
// stalls on RAW/WAW hazards and presents operands through one registered stage.
// Ports:
//   clk, reset                         clock, asynchronous active-high reset
//   in_valid/in_ready                  decode handshake (in_ready combinational)
//   src_{a,b}_addr/_used, dst_addr/_used  decoded instruction fields
//   rf_rd_addr_{a,b}, rf_rd_data_{a,b} register file read ports
//   wb_bundle                          {is_write, address, value} from write-back
//   out_valid/out_ready                execute handshake
//   op_a, op_b, out_dst_addr, out_dst_used  registered operands and destination
module register_read
    import regfile_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ADDR_W-1:0]      src_a_addr,
    input  logic                   src_a_used,
    input  logic [ADDR_W-1:0]      src_b_addr,
    input  logic                   src_b_used,
    input  logic [ADDR_W-1:0]      dst_addr,
    input  logic                   dst_used,
    output logic [ADDR_W-1:0]      rf_rd_addr_a,
    input  logic [DATA_W-1:0]      rf_rd_data_a,
    output logic [ADDR_W-1:0]      rf_rd_addr_b,
    input  logic [DATA_W-1:0]      rf_rd_data_b,
    input  logic [WB_BUNDLE_W-1:0] wb_bundle,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      op_a,
    output logic [DATA_W-1:0]      op_b,
    output logic [ADDR_W-1:0]      out_dst_addr,
    output logic                   out_dst_used
);

    wb_bundle_t wb;
    assign wb = wb_bundle_t'(wb_bundle);

    assign rf_rd_addr_a = src_a_addr;
    assign rf_rd_addr_b = src_b_addr;

    logic busy_a_c;
    logic busy_b_c;
    logic busy_dst_c;
    logic wb_hit_a_c;
    logic wb_hit_b_c;
    logic wb_hit_dst_c;
    logic hazard_c;
    logic accept_c;
    logic [DATA_W-1:0] sel_a_c;
    logic [DATA_W-1:0] sel_b_c;

    logic              out_valid_q,    out_valid_d;
    logic [DATA_W-1:0] op_a_q,         op_a_d;
    logic [DATA_W-1:0] op_b_q,         op_b_d;
    logic [ADDR_W-1:0] out_dst_addr_q, out_dst_addr_d;
    logic              out_dst_used_q, out_dst_used_d;

    reg_scoreboard u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .set_en      (accept_c && dst_used),
        .set_addr    (dst_addr),
        .clr_en      (wb.we),
        .clr_addr    (wb.addr),
        .rd_addr_a   (src_a_addr),
        .rd_addr_b   (src_b_addr),
        .rd_addr_dst (dst_addr),
        .busy_a_c    (busy_a_c),
        .busy_b_c    (busy_b_c),
        .busy_dst_c  (busy_dst_c)
    );

    // Hazard detection: a write-back landing this cycle resolves the hazard.
    always_comb begin
        wb_hit_a_c   = wb.we && (wb.addr == src_a_addr);
        wb_hit_b_c   = wb.we && (wb.addr == src_b_addr);
        wb_hit_dst_c = wb.we && (wb.addr == dst_addr);
        hazard_c     = (src_a_used && busy_a_c && !wb_hit_a_c)
                    || (src_b_used && busy_b_c && !wb_hit_b_c)
                    || (dst_used && busy_dst_c && !wb_hit_dst_c);
        in_ready     = (!out_valid_q || out_ready) && !hazard_c;
        accept_c     = in_valid && in_ready;
    end

    // Operand select: bypass beats the register file's pre-write value; unused sources read as 0.
    always_comb begin
        sel_a_c = '0;
        sel_b_c = '0;
        if (src_a_used) begin
            sel_a_c = wb_hit_a_c ? wb.data : rf_rd_data_a;
        end
        if (src_b_used) begin
            sel_b_c = wb_hit_b_c ? wb.data : rf_rd_data_b;
        end
    end

    // Output stage next state: load on accept, drop valid on a bare transfer, else hold.
    always_comb begin
        out_valid_d    = out_valid_q;
        op_a_d         = op_a_q;
        op_b_d         = op_b_q;
        out_dst_addr_d = out_dst_addr_q;
        out_dst_used_d = out_dst_used_q;
        if (accept_c) begin
            out_valid_d    = 1'b1;
            op_a_d         = sel_a_c;
            op_b_d         = sel_b_c;
            out_dst_addr_d = dst_addr;
            out_dst_used_d = dst_used;
        end else if (out_valid_q && out_ready) begin
            out_valid_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q    <= 1'b0;
            op_a_q         <= '0;
            op_b_q         <= '0;
            out_dst_addr_q <= '0;
            out_dst_used_q <= 1'b0;
        end else begin
            out_valid_q    <= out_valid_d;
            op_a_q         <= op_a_d;
            op_b_q         <= op_b_d;
            out_dst_addr_q <= out_dst_addr_d;
            out_dst_used_q <= out_dst_used_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign op_a         = op_a_q;
    assign op_b         = op_b_q;
    assign out_dst_addr = out_dst_addr_q;
    assign out_dst_used = out_dst_used_q;

endmodule : register_read

// File: tb/tb_register_read.sv
// Self-checking bench for register_read: directed scenarios plus randomized
// traffic compared against a behavioural model of the stage.
module tb_register_read;
    import regfile_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0, in_ready;
    logic [3:0] src_a_addr = '0, src_b_addr = '0, dst_addr = '0;
    logic src_a_used = 1'b0, src_b_used = 1'b0, dst_used = 1'b0;
    logic [3:0] rf_rd_addr_a, rf_rd_addr_b;
    logic [63:0] rf_rd_data_a, rf_rd_data_b;
    logic wb_we = 1'b0;
    logic [3:0] wb_a = '0;
    logic [63:0] wb_d = '0;
    logic [68:0] wb_bundle;
    logic out_valid, out_ready = 1'b1;
    logic [63:0] op_a, op_b;
    logic [3:0] out_dst_addr;
    logic out_dst_used;

    int errors = 0;
    int checks = 0;

    // Behavioural register file and stage model
    logic [63:0] rf_mem [16];
    bit          m_busy [16];
    bit          m_ov = 1'b0;
    logic [63:0] m_a = '0, m_b = '0;
    logic [3:0]  m_dst = '0;
    bit          m_du = 1'b0;

    always #5 clk = ~clk;

    assign wb_bundle    = {wb_we, wb_a, wb_d};
    assign rf_rd_data_a = rf_mem[src_a_addr];
    assign rf_rd_data_b = rf_mem[src_b_addr];

    register_read dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .src_a_addr(src_a_addr), .src_a_used(src_a_used),
        .src_b_addr(src_b_addr), .src_b_used(src_b_used),
        .dst_addr(dst_addr), .dst_used(dst_used),
        .rf_rd_addr_a(rf_rd_addr_a), .rf_rd_data_a(rf_rd_data_a),
        .rf_rd_addr_b(rf_rd_addr_b), .rf_rd_data_b(rf_rd_data_b),
        .wb_bundle(wb_bundle), .out_valid(out_valid), .out_ready(out_ready),
        .op_a(op_a), .op_b(op_b), .out_dst_addr(out_dst_addr), .out_dst_used(out_dst_used)
    );

    // Stage may take the instruction when the output slot frees and no source/destination waits on a pending write.
    function automatic bit model_ready();
        bit blocked;
        blocked = 1'b0;
        if (src_a_used && m_busy[src_a_addr] && !(wb_we && wb_a == src_a_addr)) blocked = 1'b1;
        if (src_b_used && m_busy[src_b_addr] && !(wb_we && wb_a == src_b_addr)) blocked = 1'b1;
        if (dst_used && m_busy[dst_addr] && !(wb_we && wb_a == dst_addr)) blocked = 1'b1;
        return (!m_ov || out_ready) && !blocked;
    endfunction

    function automatic logic [63:0] fetch(input bit used, input logic [3:0] a);
        if (!used) return 64'd0;
        if (wb_we && wb_a == a) return wb_d;
        return rf_mem[a];
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            foreach (m_busy[i]) m_busy[i] = 1'b0;
            m_ov = 1'b0; m_a = '0; m_b = '0; m_dst = '0; m_du = 1'b0;
        end else begin
            bit acc;
            acc = in_valid && model_ready();
            if (acc) begin
                m_ov = 1'b1;
                m_a = fetch(src_a_used, src_a_addr);
                m_b = fetch(src_b_used, src_b_addr);
                m_dst = dst_addr; m_du = dst_used;
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
            if (wb_we) begin
                rf_mem[wb_a] = wb_d;
                m_busy[wb_a] = 1'b0;
            end
            if (acc && dst_used) m_busy[dst_addr] = 1'b1;
        end
    end

    task automatic drive(input bit v, input logic [3:0] sa, input bit ua, input logic [3:0] sb,
                         input bit ub, input logic [3:0] d, input bit du, input bit ordy,
                         input bit we, input logic [3:0] wa, input logic [63:0] wd);
        in_valid = v; src_a_addr = sa; src_a_used = ua; src_b_addr = sb; src_b_used = ub;
        dst_addr = d; dst_used = du; out_ready = ordy; wb_we = we; wb_a = wa; wb_d = wd;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || op_a !== 64'd0 || op_b !== 64'd0 || out_dst_addr !== 4'd0 || out_dst_used !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b a=%h b=%h d=%h du=%b want all zero", out_valid, op_a, op_b, out_dst_addr, out_dst_used);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_basic();
        @(negedge clk);
        rf_mem[3] = 64'h11; rf_mem[5] = 64'h22;
        drive(1, 3, 1, 5, 1, 0, 0, 1, 0, 0, 0);
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || op_a !== 64'h11 || op_b !== 64'h22 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_fetch: got v=%b a=%h b=%h rdy=%b want 1/11/22/1", out_valid, op_a, op_b, in_ready);
        end
        checks++;
        if (rf_rd_addr_a !== 4'd3 || rf_rd_addr_b !== 4'd5) begin
            errors++;
            $display("FAIL rf_addr: got %h/%h want 3/5", rf_rd_addr_a, rf_rd_addr_b);
        end
        // Back-to-back accepts at full throughput
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rf_mem[4'(i + 8)] = 64'(100 + i);
            drive(1, 4'(i + 8), 1, 0, 0, 0, 0, 1, 0, 0, 0);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, in_ready); end
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || op_a !== 64'(100 + i) || op_b !== 64'd0) begin
                errors++;
                $display("FAIL b2b_op[%0d]: got v=%b a=%0d b=%0d want 1/%0d/0", i, out_valid, op_a, op_b, 100 + i);
            end
        end
    endtask

    task automatic test_raw();
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 6, 1, 1, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        rf_mem[6] = 64'd0;
        drive(1, 6, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_stall: got in_ready=%b want 0", in_ready); end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL raw_drain: got out_valid=%b want 0", out_valid); end
        @(negedge clk);
        drive(1, 6, 1, 0, 0, 0, 0, 1, 0, 6, 64'd25);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL nonwrite_wb: got in_ready=%b want 0", in_ready); end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL nonwrite_stall: got out_valid=%b want 0", out_valid); end
        @(negedge clk);
        drive(1, 6, 1, 0, 0, 0, 0, 1, 1, 6, 64'd50);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL wb_release: got in_ready=%b want 1", in_ready); end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || op_a !== 64'd50) begin
            errors++;
            $display("FAIL wb_bypass: got v=%b a=%0d want 1/50", out_valid, op_a);
        end
        @(negedge clk);
        drive(1, 6, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL busy_cleared: got in_ready=%b want 1", in_ready); end
        @(posedge clk);
    endtask

    task automatic test_backpressure();
        logic [63:0] a0;
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        rf_mem[1] = 64'hA1; rf_mem[2] = 64'hB2;
        drive(1, 1, 1, 2, 1, 9, 1, 0, 0, 0, 0);
        @(posedge clk); #1;
        a0 = op_a;
        checks++;
        if (out_valid !== 1'b1 || a0 !== 64'hA1 || op_b !== 64'hB2 || out_dst_addr !== 4'd9 || out_dst_used !== 1'b1) begin
            errors++;
            $display("FAIL bp_load: got v=%b a=%h b=%h d=%h du=%b want 1/a1/b2/9/1", out_valid, a0, op_b, out_dst_addr, out_dst_used);
        end
        rf_mem[4] = 64'hC3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1, 4, 1, 4, 1, 0, 0, 0, 0, 0, 0);
            #1;
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %b want 0", i, in_ready); end
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || op_a !== 64'hA1 || op_b !== 64'hB2 || out_dst_addr !== 4'd9) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got v=%b a=%h b=%h d=%h want 1/a1/b2/9", i, out_valid, op_a, op_b, out_dst_addr);
            end
        end
        @(negedge clk);
        drive(1, 4, 1, 4, 1, 0, 0, 1, 0, 0, 0);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got in_ready=%b want 1", in_ready); end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || op_a !== 64'hC3 || op_b !== 64'hC3 || out_dst_used !== 1'b0) begin
            errors++;
            $display("FAIL bp_next: got v=%b a=%h b=%h du=%b want 1/c3/c3/0", out_valid, op_a, op_b, out_dst_used);
        end
        // Reg 9 was marked busy by the held instruction; retire it
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 9, 64'h99);
        @(posedge clk);
    endtask

    task automatic test_set_wins();
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 3, 1, 1, 1, 3, 64'd7);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL setwin_accept: got in_ready=%b want 1", in_ready); end
        @(posedge clk);
        @(negedge clk);
        drive(1, 3, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL setwin_stall: got in_ready=%b want 0", in_ready); end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 3, 64'd8);
        @(posedge clk);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        rf_mem[5] = 64'h55;
        drive(1, 5, 1, 5, 1, 6, 1, 1, 0, 0, 0);
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || op_a !== 64'h55) begin
            errors++;
            $display("FAIL rst_setup: got v=%b a=%h want 1/55", out_valid, op_a);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || op_a !== 64'd0 || op_b !== 64'd0 || out_dst_used !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got v=%b a=%h b=%h du=%b want 0/0/0/0", out_valid, op_a, op_b, out_dst_used);
        end
        @(negedge clk);
        reset = 1'b0;
        drive(1, 6, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got in_ready=%b want 1", in_ready); end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL post_reset_accept: got out_valid=%b want 1", out_valid); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            drive($urandom_range(0, 9) < 7, 4'($urandom_range(0, 3)), 1'($urandom),
                  4'($urandom_range(0, 3)), 1'($urandom), 4'($urandom_range(0, 3)), 1'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 4, 4'($urandom_range(0, 3)),
                  {$urandom, $urandom});
            #1;
            checks++;
            if (in_ready !== model_ready()) begin
                errors++;
                $display("FAIL rand_ready[%0d]: got %b want %b", n, in_ready, model_ready());
            end
            @(posedge clk); #1;
            checks++;
            if (out_valid !== m_ov || op_a !== m_a || op_b !== m_b || out_dst_addr !== m_dst || out_dst_used !== m_du) begin
                errors++;
                $display("FAIL rand_out[%0d]: got v=%b a=%h b=%h d=%h du=%b want v=%b a=%h b=%h d=%h du=%b",
                         n, out_valid, op_a, op_b, out_dst_addr, out_dst_used, m_ov, m_a, m_b, m_dst, m_du);
            end
        end
    endtask

    initial begin
        foreach (rf_mem[i]) rf_mem[i] = 64'(i * 16);
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        test_reset();
        test_basic();
        test_raw();
        test_backpressure();
        test_set_wins();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_register_read
